// File: rtl/apb_pkg.sv
// Shared types and default sizing for the multi-slave APB master.
// State encoding is fixed so waveforms stay comparable across builds.
package apb_pkg;

    localparam int APB_ADDR_W      = 32;
    localparam int APB_DATA_W      = 32;
    localparam int APB_NUM_SLV     = 4;
    localparam int APB_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps the top address bits to a slave index and one-hot select.
// NUM_SLV is a power of two, so every index value names a real slave.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int NUM_SLV = APB_NUM_SLV,
    parameter int IDX_W   = $clog2(NUM_SLV)
) (
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic [IDX_W-1:0]   idx_o
);

    assign idx_o = addr_i[ADDR_W-1 -: IDX_W];
    assign sel_o = NUM_SLV'(1) << idx_o;

endmodule

// File: rtl/apb_multi_master.sv
// Single-outstanding APB master fanning out to NUM_SLV slaves.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles.
module apb_multi_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int NUM_SLV     = APB_NUM_SLV,
    parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
    input  logic                      P_clk,
    input  logic                      P_rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_W-1:0]         cmd_addr,
    input  logic [DATA_W-1:0]         cmd_wdata,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        P_sel,
    output logic                      P_enable,
    output logic                      P_write,
    output logic [ADDR_W-1:0]         P_addr,
    output logic [DATA_W-1:0]         P_wdata,
    input  logic [NUM_SLV-1:0]        P_ready_s,
    input  logic [NUM_SLV-1:0]        P_slverr_s,
    input  logic [NUM_SLV*DATA_W-1:0] P_rdata_s
);

    localparam int IDX_W = $clog2(NUM_SLV);

    apb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_SLV-1:0]  sel_q, sel_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NUM_SLV-1:0]  dec_sel;
    logic [IDX_W-1:0]    dec_idx;
    logic                slv_rdy;
    logic                slv_err;
    logic [DATA_W-1:0]   slv_rdata;

    apb_addr_decoder #(
        .ADDR_W  (ADDR_W),
        .NUM_SLV (NUM_SLV),
        .IDX_W   (IDX_W)
    ) u_dec (
        .addr_i (cmd_addr),
        .sel_o  (dec_sel),
        .idx_o  (dec_idx)
    );

    // Only the addressed slave's response lines are ever looked at.
    assign slv_rdy   = P_ready_s[idx_q];
    assign slv_err   = P_slverr_s[idx_q];
    assign slv_rdata = P_rdata_s[int'(idx_q)*DATA_W +: DATA_W];

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] tmo_q, tmo_d;
    logic       tmo_hit;
    assign tmo_hit = (tmo_q == TMO_LAST);
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    write_d = cmd_write;
                    idx_d   = dec_idx;
                    sel_d   = dec_sel;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            ST_ACCESS: begin
                if (slv_rdy) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = slv_err;
                    rsp_rdata_d = write_q ? '0 : slv_rdata;
                    state_d     = ST_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge P_clk) begin
        if (P_rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge P_clk) begin
        if (P_rst) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign P_enable  = (state_q == ST_ACCESS);
    assign P_sel     = (state_q == ST_IDLE) ? '0 : sel_q;
    assign P_write   = write_q;
    assign P_addr    = addr_q;
    assign P_wdata   = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_multi_master.sv
// Directed bench for apb_multi_master with a response scoreboard.
// Builds with or without APB_TIMEOUT_EN.
module tb_apb_multi_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]  cmd_addr;
    logic [DW-1:0]  cmd_wdata;
    logic           rsp_valid, rsp_err;
    logic [DW-1:0]  rsp_rdata;
    logic [NS-1:0]  P_sel;
    logic           P_enable, P_write;
    logic [AW-1:0]  P_addr;
    logic [DW-1:0]  P_wdata;
    logic [NS-1:0]  rdy_s, err_s;
    logic [NS*DW-1:0] rdata_s;

    int            ws;
    int            wcnt;
    logic [NS-1:0] noise, err_mask;
    logic          prev_rv;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    apb_multi_master #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT_CYC(16)
    ) dut (
        .P_clk(clk), .P_rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .P_sel(P_sel), .P_enable(P_enable), .P_write(P_write),
        .P_addr(P_addr), .P_wdata(P_wdata),
        .P_ready_s(rdy_s), .P_slverr_s(err_s),
        .P_rdata_s(rdata_s)
    );

    // Slave model: selected slave is ready after ws ACCESS cycles;
    // noise drives ready on slaves that are not selected.
    always @(posedge clk) wcnt <= P_enable ? wcnt + 1 : 0;
    assign rdy_s = ((P_enable && wcnt == ws) ? P_sel : '0)
                 | (noise & ~P_sel);
    assign err_s = err_mask;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot_sel", 64'($countones(P_sel) <= 1), 64'd1);
            chk("rsp_no_repeat", 64'(rsp_valid & prev_rv), 64'd0);
        end
        prev_rv <= rsp_valid;
    end

    task automatic start(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int wsi,
                         input logic [NS-1:0] nz, input logic [NS-1:0] em,
                         input logic [NS-1:0] es);
        @(negedge clk);
        ws = wsi; noise = nz; err_mask = em;
        cmd_valid = 1'b1; cmd_write = w;
        cmd_addr = a; cmd_wdata = d;
        chk("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("setup_sel", P_sel, es);
        chk("setup_en", P_enable, 0);
        chk("setup_write", P_write, w);
        chk("setup_addr", P_addr, a);
        chk("setup_wdata", P_wdata, d);
    endtask

    task automatic wait_rsp(input logic [NS-1:0] es, input int bound,
                            output int n);
        bit   got;
        exp_t e;
        n = 0; got = 0;
        while (!got && n < bound) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1;
            else begin
                chk("acc_sel", P_sel, es);
                chk("acc_en", P_enable, 1);
            end
        end
        if (!got) chk("rsp_timeout", rsp_valid, 1);
        else begin
            chk("rsp_cmd_ready", cmd_ready, 1);
            chk("rsp_sel_clear", P_sel, 0);
            chk("sb_nonempty", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
            end
        end
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int wsi,
                         input logic [NS-1:0] nz, input logic [NS-1:0] em,
                         input logic [NS-1:0] es, input int exp_acc,
                         input logic [DW-1:0] exp_rd, input logic exp_err);
        int n;
        sb.push_back('{exp_rd, exp_err});
        start(w, a, d, wsi, nz, em, es);
        wait_rsp(es, 50, n);
        chk("access_cycles", 64'(n - 1), 64'(exp_acc));
        chk("latency", 64'(n + 1), 64'(exp_acc + 2));
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0;
        ws = 0; noise = '0; err_mask = '0;
        for (int k = 0; k < NS; k++)
            rdata_s[k*DW +: DW] = 32'hA0A0_0000 + k;
        rdata_s[3*DW +: DW] = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_sel", P_sel, 0);
        chk("rst_en", P_enable, 0);
        chk("rst_write", P_write, 0);
        chk("rst_addr", P_addr, 0);
        chk("rst_wdata", P_wdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);

        // zero-wait write to slave 1, other slaves flag errors
        issue(1, 32'h4000_0010, 32'hDEAD_BEEF, 0, 4'b0000, 4'b1101,
              4'b0010, 1, 32'h0, 0);

        // read slave 3, 2 wait states, slave 0 ready noise
        issue(0, 32'hC000_0004, 32'h0, 2, 4'b0001, 4'b0111,
              4'b1000, 3, 32'h1234_5678, 0);

        // slave 2 returns an error
        issue(1, 32'h8000_0000, 32'h0BAD_F00D, 1, 4'b0000, 4'b0100,
              4'b0100, 2, 32'h0, 1);
        @(negedge clk);
        chk("err_one_cycle_valid", rsp_valid, 0);
        chk("err_one_cycle_err", rsp_err, 0);

        // back-to-back with cmd_valid held
        @(negedge clk);
        ws = 0; noise = '0; err_mask = '0;
        cmd_valid = 1'b1; cmd_write = 1'b0;
        cmd_addr = 32'h4000_0000; cmd_wdata = '0;
        sb.push_back('{32'hA0A0_0001, 1'b0});
        @(posedge clk);
        #1 cmd_write = 1'b1;
        cmd_addr = 32'h8000_0008; cmd_wdata = 32'h5555_AAAA;
        sb.push_back('{32'h0, 1'b0});
        @(negedge clk);
        chk("b2b1_setup_sel", P_sel, 4'b0010);
        chk("b2b_not_ready", cmd_ready, 0);
        wait_rsp(4'b0010, 20, n);
        chk("b2b_lat1", 64'(n + 1), 64'd3);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b2_setup_sel", P_sel, 4'b0100);
        chk("b2b2_setup_write", P_write, 1);
        chk("b2b2_setup_wdata", P_wdata, 32'h5555_AAAA);
        wait_rsp(4'b0100, 20, n);
        chk("b2b_interval", 64'(n + 1), 64'd3);

        // slave 0 never ready
`ifdef APB_TIMEOUT_EN
        sb.push_back('{32'h0, 1'b1});
        start(0, 32'h0000_0020, 32'h0, 100000, 4'b1110, 4'b0000,
              4'b0001);
        wait_rsp(4'b0001, 40, n);
        chk("tmo_access_cycles", 64'(n - 1), 64'd16);
        start(1, 32'h0000_0040, 32'h77, 100000, 4'b0000, 4'b0000,
              4'b0001);
        repeat (2) @(negedge clk);
`else
        start(0, 32'h0000_0020, 32'h0, 100000, 4'b1110, 4'b0000,
              4'b0001);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("hang_no_rsp", rsp_valid, 0);
        end
        chk("hang_still_access", P_enable, 1);
`endif

        // reset for 2 cycles in the middle of ACCESS
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_sel1", P_sel, 0);
        chk("midrst_en1", P_enable, 0);
        chk("midrst_rv1", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_sel2", P_sel, 0);
        chk("midrst_rv2", rsp_valid, 0);
        rst = 1'b0;
        chk("postrst_ready", cmd_ready, 1);
        @(negedge clk);
        chk("postrst_rv", rsp_valid, 0);

        // recovery read from slave 2
        issue(0, 32'h8000_0100, 32'h0, 0, 4'b0000, 4'b0000,
              4'b0100, 1, 32'hA0A0_0002, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_multi_master.md
APB_MULTI_MASTER -- requirements
Module: apb_multi_master

Interface
REQ-001 Parameter ADDR_W, default 32, address width in bits.
REQ-002 Parameter DATA_W, default 32, data width in bits.
REQ-003 Parameter NUM_SLV, default 4, slave count; power of two, 2..16.
REQ-004 Parameter TIMEOUT_CYC, default 16, ACCESS-phase cycle limit; valid range 1..255.
REQ-005 P_clk  in  1  sole clock; all logic on rising edge.
REQ-006 P_rst  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  request present.
REQ-008 cmd_ready  out  1  request accepted when high together with cmd_valid.
REQ-009 cmd_write  in  1  1 = write, 0 = read.
REQ-010 cmd_addr  in  ADDR_W  byte address; top log2(NUM_SLV) bits select the slave.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  DATA_W  read data; zero for writes and aborts.
REQ-014 rsp_err  out  1  slave error or timeout.
REQ-015 P_sel  out  NUM_SLV  one-hot select.
REQ-016 P_enable, P_write  out  1 each  APB control.
REQ-017 P_addr  out  ADDR_W;  P_wdata  out  DATA_W  APB address and write data.
REQ-018 P_ready_s  in  NUM_SLV  per-slave ready.
REQ-019 P_slverr_s  in  NUM_SLV  per-slave error.
REQ-020 P_rdata_s  in  NUM_SLV*DATA_W  per-slave read data, slave k at bits [k*DATA_W +: DATA_W].

Function
REQ-021 FSM shall have states IDLE, SETUP, ACCESS.
REQ-022 cmd_ready shall be high only in IDLE; acceptance registers addr, wdata, write, and decoded index, and moves to SETUP.
REQ-023 SETUP shall last exactly one cycle: P_sel[idx]=1, P_enable=0, P_addr/P_wdata/P_write driven from latched values; next state ACCESS.
REQ-024 ACCESS shall hold P_sel[idx]=1, P_enable=1, and all APB address/data/control stable until P_ready_s[idx]=1.
REQ-025 Only P_ready_s/P_slverr_s/P_rdata_s of the selected slave shall be observed; other slaves' inputs are ignored.
REQ-026 On P_ready_s[idx]=1 in ACCESS: next cycle rsp_valid=1, rsp_err=P_slverr_s[idx], rsp_rdata=slave data (read) or 0 (write); FSM returns to IDLE.
REQ-027 Zero-wait latency: acceptance edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3.
REQ-028 cmd_ready shall be high in the rsp_valid cycle, so back-to-back commands have a 3-cycle issue interval.
REQ-029 Outside SETUP/ACCESS, P_sel=0 and P_enable=0; rsp_valid is never high for two consecutive cycles.
REQ-030 Writes to unselected slaves shall never occur: at most one P_sel bit is high.

Reset
REQ-031 While P_rst=1 at an edge: state=IDLE; P_sel, P_enable, P_write, P_addr, P_wdata, rsp_valid, rsp_rdata, rsp_err=0; cmd_ready=1 in the first cycle after reset.
REQ-032 Reset during SETUP or ACCESS shall drop the transfer with no rsp_valid; P_sel clears on that edge.

Configuration
REQ-033 With APB_TIMEOUT_EN defined: an 8-bit counter shall count ACCESS cycles; if TIMEOUT_CYC cycles pass without ready, the block shall drop P_sel/P_enable, pulse rsp_valid with rsp_err=1 and rsp_rdata=0, and return to IDLE.
REQ-034 Without APB_TIMEOUT_EN: no counter; ACCESS waits indefinitely for ready.

Structure
REQ-035 Package apb_pkg shall hold the state enum apb_state_e and default parameter constants.
REQ-036 Sub-module apb_addr_decoder shall map the address MSBs to a one-hot select and an index.

Verification
REQ-037 Reset: assert P_rst for 2 cycles mid-ACCESS -> P_sel=0, no rsp_valid, cmd_ready=1 after release.
REQ-038 Zero-wait write to 0x4000_0010 (slave 1 of 4), data 0xDEAD_BEEF -> P_sel=4'b0010, P_wdata=0xDEAD_BEEF, rsp_valid 3 cycles after acceptance, rsp_err=0.
REQ-039 Read from slave 3 with 2 wait states, P_rdata_s slice = 0x1234_5678 -> ACCESS lasts 3 cycles, rsp_rdata=0x1234_5678, other slave data ignored.
REQ-040 Slave 2 returns P_slverr_s=1 on ready -> rsp_err=1 for one cycle.
REQ-041 APB_TIMEOUT_EN, TIMEOUT_CYC=16, slave never ready -> rsp_valid with rsp_err=1 after 16 ACCESS cycles; without the macro, no rsp_valid after 100 cycles.
REQ-042 Two back-to-back commands with cmd_valid held high -> second accepted in the rsp_valid cycle of the first, never with two P_sel bits high.
